// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window tracker.
// CONV_WTRK_STRIDE_EN selects whether the STRIDE parameter is honoured (defined)
// or the stride is fixed at 1 (undefined).
package conv_pkg;

  localparam int CNT_W_DEF = 14;

  // Stride actually used by the hardware for a requested stride.
  function automatic int eff_stride(input int stride);
`ifdef CONV_WTRK_STRIDE_EN
    return stride;
`else
    return 1;
`endif
  endfunction

  // Output-map edge length for an input edge DIM, kernel K and requested stride.
  function automatic int out_dim(input int dim, input int k, input int stride);
    if (eff_stride(stride) < 1 || dim < k) return 0;
    return (dim - k) / eff_stride(stride) + 1;
  endfunction

  // True when a CNT_W-bit counter can hold max(w, h) - 1.
  function automatic bit cnt_w_ok(input int w, input int h, input int cnt_w);
    int m;
    m = (w > h) ? w : h;
    if (cnt_w >= 31) return 1'b1;
    return (m - 1) < (1 << cnt_w);
  endfunction

endpackage

// File: rtl/conv_axis_counter.sv
// One raster axis: position index, stride phase and output-map counter.
// Phase logic exists only when CONV_WTRK_STRIDE_EN is defined.
module conv_axis_counter
  import conv_pkg::*;
#(
  parameter int DIM    = 100,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] out_cnt,
  output logic             wrap,
  output logic             pos_valid
);

  localparam logic [CNT_W-1:0] IDX_LAST      = CNT_W'(DIM - 1);
  localparam logic [CNT_W-1:0] IDX_FIRST_WIN = CNT_W'(K - 1);

  if (STRIDE < 1) begin : g_bad_stride
    $error("conv_axis_counter: STRIDE must be at least 1");
  end

  logic [CNT_W-1:0] idx_reg;
  logic [CNT_W-1:0] idx_next;
  logic [CNT_W-1:0] out_cnt_reg;
  logic             at_last;
  logic             phase_zero;

  assign at_last  = (idx_reg == IDX_LAST);
  assign idx_next = at_last ? '0 : idx_reg + CNT_W'(1);
  assign wrap     = step && at_last;

`ifdef CONV_WTRK_STRIDE_EN
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(STRIDE - 1);
  logic [CNT_W-1:0] phase_reg;

  // Phase restarts when the index lands on the first window position, then counts modulo stride.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      phase_reg <= '0;
    end else if (clear) begin
      phase_reg <= '0;
    end else if (step) begin
      if (idx_next == IDX_FIRST_WIN || phase_reg == PH_LAST) phase_reg <= '0;
      else phase_reg <= phase_reg + CNT_W'(1);
    end
  end

  assign phase_zero = (phase_reg == '0);
`else
  // Stride is fixed at 1: every position past the kernel edge is a window position.
  assign phase_zero = 1'b1;
`endif

  assign pos_valid = (idx_reg >= IDX_FIRST_WIN) && phase_zero;
  assign out_cnt   = out_cnt_reg;

  // Index advances per step; the output counter counts valid positions and clears on wrap.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx_reg     <= '0;
      out_cnt_reg <= '0;
    end else if (clear) begin
      idx_reg     <= '0;
      out_cnt_reg <= '0;
    end else if (step) begin
      idx_reg <= idx_next;
      if (at_last) out_cnt_reg <= '0;
      else if (pos_valid) out_cnt_reg <= out_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_window_tracker.sv
// Raster-scan window tracker for a conv layer: flags pixels completing a KxK
// window at the configured stride and reports the output-map coordinates.
// Stride support is compiled in with CONV_WTRK_STRIDE_EN.
module conv_window_tracker
  import conv_pkg::*;
#(
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clear,
  output logic             Out_Valid,
  output logic [CNT_W-1:0] Out_Col,
  output logic [CNT_W-1:0] Out_Row,
  output logic             Row_End,
  output logic             Frame_End
);

  if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
    $error("conv_window_tracker: K must lie in 1..min(IMG_W, IMG_H)");
  end
  if (!cnt_w_ok(IMG_W, IMG_H, CNT_W)) begin : g_bad_cnt_w
    $error("conv_window_tracker: CNT_W too narrow for the map size");
  end
  if (out_dim(IMG_W, K, STRIDE) < 1 || out_dim(IMG_H, K, STRIDE) < 1) begin : g_bad_out
    $error("conv_window_tracker: empty output map");
  end

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] row_cnt;
  logic             col_wrap;
  logic             row_wrap;
  logic             col_pos_valid;
  logic             row_pos_valid;
  logic             window;

  conv_axis_counter #(
    .DIM(IMG_W), .K(K), .STRIDE(STRIDE), .CNT_W(CNT_W)
  ) u_col (
    .Clk(Clk), .Rst(Rst), .step(En), .clear(Clear),
    .out_cnt(col_cnt), .wrap(col_wrap), .pos_valid(col_pos_valid)
  );

  // The row axis advances only when a row is finished.
  conv_axis_counter #(
    .DIM(IMG_H), .K(K), .STRIDE(STRIDE), .CNT_W(CNT_W)
  ) u_row (
    .Clk(Clk), .Rst(Rst), .step(col_wrap), .clear(Clear),
    .out_cnt(row_cnt), .wrap(row_wrap), .pos_valid(row_pos_valid)
  );

  assign window = col_pos_valid && row_pos_valid;

  // Registered window strobe, held coordinates and boundary pulses.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Out_Valid <= 1'b0;
      Out_Col   <= '0;
      Out_Row   <= '0;
      Row_End   <= 1'b0;
      Frame_End <= 1'b0;
    end else if (Clear) begin
      Out_Valid <= 1'b0;
      Out_Col   <= '0;
      Out_Row   <= '0;
      Row_End   <= 1'b0;
      Frame_End <= 1'b0;
    end else begin
      Out_Valid <= En && window;
      Row_End   <= col_wrap;
      Frame_End <= row_wrap;
      if (En && window) begin
        Out_Col <= col_cnt;
        Out_Row <= row_cnt;
      end
    end
  end

endmodule

// File: doc/conv_window_tracker.md
# conv_window_tracker

Parametrised raster-scan position tracker for convolution layers. Counts the accepted pixels of an IMG_W × IMG_H feature map streamed in row-major order. It flags each pixel that completes a valid K × K window at the configured stride, and reports the output-map coordinates of that window. It sits beside the line buffers of each conv layer and gates the MAC array's result strobe.

## Interface
- IMG_W, 100: input map width in pixels (≥ K)
- IMG_H, 100: input map height in pixels (≥ K)
- K, 3: kernel edge length (1..IMG_W, 1..IMG_H)
- STRIDE, 1: window stride (≥ 1; forced to 1 when the stride feature is compiled out)
- CNT_W, 14: width of all coordinate counters/outputs (must hold max(IMG_W, IMG_H) − 1)
- Clk  in  1  clock; all state changes on rising edge
- Rst  in  1  asynchronous, active-low reset
- En  in  1  pixel accepted this cycle
- Clear  in  1  synchronous restart to pixel (0,0); priority over En
- Out_Valid  out  1  registered; high for one cycle after a window-completing pixel
- Out_Col  out  CNT_W  output-map column of the last valid window
- Out_Row  out  CNT_W  output-map row of the last valid window
- Row_End  out  1  registered pulse; the last accepted pixel was column IMG_W−1
- Frame_End  out  1  registered pulse; the last accepted pixel was (IMG_H−1, IMG_W−1)

## Operation
- Internal state per axis: index (0..DIM−1) of the *next* pixel, plus a stride phase (0..STRIDE−1). The phase is reset to 0 when index reaches K−1 and increments modulo STRIDE thereafter. No divider or modulo operator is used.
- On En=1 with Clear=0, the pixel at (r,c) = (row idx, col idx) is accepted:
  - col idx advances. At IMG_W−1 it wraps to 0 and row idx advances.
  - At (IMG_H−1, IMG_W−1) both indices wrap to 0. The next frame starts with no gap.
- A window is complete when r ≥ K−1, c ≥ K−1, row phase = 0 and col phase = 0.
- On a complete window:
  - Out_Valid ← 1.
  - Out_Col ← output-col counter, which increments per valid column and clears at row wrap.
  - Out_Row ← output-row counter, which increments on the row wrap of each valid row and clears at frame wrap.
- En=0 or a non-completing pixel: Out_Valid ← 0. Out_Col/Out_Row hold their last value.
- Row_End and Frame_End are set from the accepted pixel's position and are 0 on any cycle without acceptance.
- Clear=1: all counters, phases and outputs are zeroed next edge, regardless of En. The pixel presented with Clear is discarded.
- Reset: all outputs and state are 0. A reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- K=1, STRIDE=1: every accepted pixel is valid.
- Output map size is floor((IMG_W−K)/STRIDE)+1 columns by floor((IMG_H−K)/STRIDE)+1 rows. Trailing pixels beyond the last full stride never assert Out_Valid.

## Timing
- Latency: exactly 1 cycle from the En edge to Out_Valid/Row_End/Frame_End/Out_Col/Out_Row.
- Throughput: one pixel per cycle. Back-to-back En across row and frame boundaries is supported.
- No backpressure. En is the only handshake, and the block always accepts.
- Simultaneous Row_End and Out_Valid are legal (last column valid). Frame_End always coincides with Row_End.

## Configuration
- CONV_WTRK_STRIDE_EN defined: the STRIDE parameter is honoured and the phase counters are instantiated.
- Macro undefined: phase logic is removed and stride is fixed at 1, whatever the STRIDE value. Every pixel with r ≥ K−1 and c ≥ K−1 is valid.

## Structure
- Shared package conv_pkg:
  - default CNT_W
  - a function computing output-map dimension (DIM, K, STRIDE), used by the bench and by the parameter checks
  - elaboration-time assertions: K ≤ IMG_W, K ≤ IMG_H, STRIDE ≥ 1, and CNT_W sufficient.
- Sub-module conv_axis_counter, instantiated twice (column, row). It holds index, stride phase, output counter, wrap flag and a valid-position flag. The row instance is stepped by the column wrap.

## Test plan
- Default params (100×100, K=3, S=1), En held high 10000 cycles → 98 Out_Valid per row and 9604 total. First valid one cycle after pixel (2,2) with Out_Col=0, Out_Row=0. Last valid shows Out_Col=97, Out_Row=97, coinciding with Frame_End.
- IMG_W=IMG_H=8, K=3, STRIDE=2 (macro defined) → valid at c,r ∈ {2,4,6}. Output 3×3, Out_Col cycles 0,1,2. Same params with the macro undefined → 6×6 outputs.
- Random En duty 30% over two frames → the valid count per frame is identical to continuous streaming. Outputs hold while En=0, and frame 2 repeats frame 1 coordinates.
- Clear asserted with En=1 at pixel (5,40) → the pixel is dropped and all outputs are 0 next cycle. The following accepted pixel is treated as (0,0).
- Rst pulsed low mid-row, asynchronous to Clk → outputs 0 immediately. After release, the first valid occurs after the (K−1)·IMG_W+K-th accepted pixel.
- K=1, STRIDE=1, 4×4 → Out_Valid high on all 16 pixels, and Row_End on columns 3.
